// File: rtl/ama_riscv_ret_trace_buf_pkg.sv
// rtl/ama_riscv_ret_trace_buf_pkg.sv - shared types and constants for the retirement trace buffer
package ama_riscv_ret_trace_buf_pkg;

  // Retired-instruction record as it sits in the FIFO and leaves on out_entry
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        branch;
    logic        taken;
    logic        bp_hit;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_size;
  } ret_trace_entry_t;

  localparam int RET_TRACE_ENTRY_W = $bits(ret_trace_entry_t);

  // Size codes below ST_BASE are loads, ST_BASE..NA-1 are stores, NA is no access
  localparam logic [3:0] DMEM_SIZE_NA      = 4'd8;
  localparam logic [3:0] DMEM_SIZE_ST_BASE = 4'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } ret_trace_state_t;

endpackage

// File: rtl/ama_riscv_ret_fifo.sv
// rtl/ama_riscv_ret_fifo.sv - synchronous DEPTH x W FIFO with push/pop/full/empty/count
module ama_riscv_ret_fifo
  import ama_riscv_ret_trace_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = RET_TRACE_ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  // Head is zero when empty so the consumer never sees stale data
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards any queued entries
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: it is only visible through a non-empty head
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ama_riscv_ret_trace_buf.sv
// rtl/ama_riscv_ret_trace_buf.sv - retirement trace FIFO, commit counters and tohost end-of-test detect (option RET_TRACE_BP_EN)
module ama_riscv_ret_trace_buf
  import ama_riscv_ret_trace_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_retired,
  input  logic [31:0]      r_inst,
  input  logic [31:0]      r_pc,
  input  logic             r_branch_inst,
  input  logic             r_branch_taken,
  input  logic             r_bp_hit,
  input  logic [31:0]      r_dmem_addr,
  input  logic [3:0]       r_dmem_size,
  input  logic [31:0]      csr_tohost,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [102:0]     out_entry,
  output logic [CNT_W-1:0] cnt_inst,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_bp_hit,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_drop,
  output logic             overflow,
  output logic             done,
  output logic [30:0]      exit_code
);

  localparam int CW = $clog2(DEPTH) + 1;

`ifdef RET_TRACE_BP_EN
  localparam logic BP_EN = 1'b1;
`else
  localparam logic BP_EN = 1'b0;
`endif

  ret_trace_state_t state_q, state_d;
  logic [30:0]      exit_code_q, exit_code_d;
  logic [CNT_W-1:0] cnt_inst_q, cnt_inst_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0] cnt_load_q, cnt_load_d;
  logic [CNT_W-1:0] cnt_store_q, cnt_store_d;
  logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;
  logic             overflow_q, overflow_d;

  ret_trace_entry_t rec;
  logic             accept, push, pop;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;

  // Pack the retiring record; the bp_hit bit is only kept when prediction tracing is built in
  always_comb begin
    rec.inst      = r_inst;
    rec.pc        = r_pc;
    rec.branch    = r_branch_inst;
    rec.taken     = r_branch_taken;
    rec.bp_hit    = BP_EN & r_bp_hit;
    rec.dmem_addr = r_dmem_addr;
    rec.dmem_size = r_dmem_size;
  end

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign accept    = (state_q == RUN) && inst_retired;
  assign push      = accept && (!fifo_full || pop);

  ama_riscv_ret_fifo #(
    .DEPTH (DEPTH),
    .W     (RET_TRACE_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rec),
    .pop       (pop),
    .pop_data  (out_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // End-of-test FSM: tohost bit 0 stops capture, then wait for the logger to empty the FIFO
  always_comb begin
    state_d     = state_q;
    exit_code_d = exit_code_q;
    case (state_q)
      RUN: begin
        if (csr_tohost[0]) begin
          state_d     = DRAIN;
          exit_code_d = csr_tohost[31:1];
        end
      end
      DRAIN: begin
        if ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // Commit statistics: every record seen in RUN counts, whether queued or dropped
  always_comb begin
    cnt_inst_d   = cnt_inst_q;
    cnt_branch_d = cnt_branch_q;
    cnt_taken_d  = cnt_taken_q;
    cnt_load_d   = cnt_load_q;
    cnt_store_d  = cnt_store_q;
    cnt_drop_d   = cnt_drop_q;
    overflow_d   = overflow_q;
    if (accept) begin
      cnt_inst_d = cnt_inst_q + CNT_W'(1);
      if (r_branch_inst) begin
        cnt_branch_d = cnt_branch_q + CNT_W'(1);
      end
      if (r_branch_inst && r_branch_taken) begin
        cnt_taken_d = cnt_taken_q + CNT_W'(1);
      end
      if (r_dmem_size < DMEM_SIZE_ST_BASE) begin
        cnt_load_d = cnt_load_q + CNT_W'(1);
      end else if (r_dmem_size < DMEM_SIZE_NA) begin
        cnt_store_d = cnt_store_q + CNT_W'(1);
      end
      if (!push) begin
        cnt_drop_d = cnt_drop_q + CNT_W'(1);
        overflow_d = 1'b1;
      end
    end
  end

  // State, exit code and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      exit_code_q  <= '0;
      cnt_inst_q   <= '0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_load_q   <= '0;
      cnt_store_q  <= '0;
      cnt_drop_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      exit_code_q  <= exit_code_d;
      cnt_inst_q   <= cnt_inst_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
      cnt_load_q   <= cnt_load_d;
      cnt_store_q  <= cnt_store_d;
      cnt_drop_q   <= cnt_drop_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef RET_TRACE_BP_EN
  logic [CNT_W-1:0] cnt_bp_hit_q, cnt_bp_hit_d;

  // Correctly predicted conditional branches
  always_comb begin
    cnt_bp_hit_d = cnt_bp_hit_q;
    if (accept && r_branch_inst && r_bp_hit) begin
      cnt_bp_hit_d = cnt_bp_hit_q + CNT_W'(1);
    end
  end

  // Predictor-hit counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_bp_hit_q <= '0;
    end else begin
      cnt_bp_hit_q <= cnt_bp_hit_d;
    end
  end

  assign cnt_bp_hit = cnt_bp_hit_q;
`else
  assign cnt_bp_hit = '0;
`endif

  assign cnt_inst   = cnt_inst_q;
  assign cnt_branch = cnt_branch_q;
  assign cnt_taken  = cnt_taken_q;
  assign cnt_load   = cnt_load_q;
  assign cnt_store  = cnt_store_q;
  assign cnt_drop   = cnt_drop_q;
  assign overflow   = overflow_q;
  assign exit_code  = exit_code_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_ama_riscv_ret_trace_buf.sv
// tb/tb_ama_riscv_ret_trace_buf.sv - randomized self-checking bench for ama_riscv_ret_trace_buf
module tb_ama_riscv_ret_trace_buf;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inst_retired = 1'b0;
  logic [31:0]      r_inst = '0;
  logic [31:0]      r_pc = '0;
  logic             r_branch_inst = 1'b0;
  logic             r_branch_taken = 1'b0;
  logic             r_bp_hit = 1'b0;
  logic [31:0]      r_dmem_addr = '0;
  logic [3:0]       r_dmem_size = 4'd8;
  logic [31:0]      csr_tohost = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [102:0]     out_entry;
  logic [CNT_W-1:0] cnt_inst, cnt_branch, cnt_taken, cnt_bp_hit;
  logic [CNT_W-1:0] cnt_load, cnt_store, cnt_drop;
  logic             overflow, done;
  logic [30:0]      exit_code;

  ama_riscv_ret_trace_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .inst_retired(inst_retired), .r_inst(r_inst), .r_pc(r_pc),
    .r_branch_inst(r_branch_inst), .r_branch_taken(r_branch_taken), .r_bp_hit(r_bp_hit),
    .r_dmem_addr(r_dmem_addr), .r_dmem_size(r_dmem_size), .csr_tohost(csr_tohost),
    .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
    .cnt_inst(cnt_inst), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken),
    .cnt_bp_hit(cnt_bp_hit), .cnt_load(cnt_load), .cnt_store(cnt_store),
    .cnt_drop(cnt_drop), .overflow(overflow), .done(done), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: a queue of expected trace entries plus plain counters
  logic [102:0] mq[$];
  int           m_phase;   // 0 capturing, 1 waiting for logger, 2 finished
  logic [31:0]  m_inst, m_branch, m_taken, m_bp, m_load, m_store, m_drop;
  logic         m_ovf;
  logic [30:0]  m_exit;

  // Per-step snapshot: DUT outputs before the edge and the model's view of them
  logic [104:0] o_out, e_out;   // {valid, done, entry}
  int           n_pops;

  function automatic logic [255:0] model_stats();
    return {m_inst, m_branch, m_taken, m_bp, m_load, m_store, m_drop, m_ovf, m_exit};
  endfunction

  function automatic logic [255:0] dut_stats();
    return {cnt_inst, cnt_branch, cnt_taken, cnt_bp_hit, cnt_load, cnt_store, cnt_drop,
            overflow, exit_code};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_phase = 0;
    m_inst = 0; m_branch = 0; m_taken = 0; m_bp = 0;
    m_load = 0; m_store = 0; m_drop = 0;
    m_ovf = 1'b0; m_exit = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; inst_retired = 1'b0; out_ready = 1'b0; csr_tohost = '0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
  endtask

  // One clock cycle: drive inputs, snapshot outputs, advance the model by the retirement rules
  task automatic step(input logic ret, input logic [31:0] inst, input logic [31:0] pc,
                      input logic br, input logic tk, input logic bp,
                      input logic [31:0] addr, input logic [3:0] size,
                      input logic rdy, input logic [31:0] tohost);
    logic [102:0] rec;
    logic         bp_kept;
    logic         pop;
    @(negedge clk);
    inst_retired = ret; r_inst = inst; r_pc = pc; r_branch_inst = br;
    r_branch_taken = tk; r_bp_hit = bp; r_dmem_addr = addr; r_dmem_size = size;
    out_ready = rdy; csr_tohost = tohost;
    #1;
    o_out = {out_valid, done, out_entry};
    e_out = {mq.size() != 0, m_phase == 2, (mq.size() != 0) ? mq[0] : 103'd0};
`ifdef RET_TRACE_BP_EN
    bp_kept = bp;
`else
    bp_kept = 1'b0;
`endif
    rec = {inst, pc, br, tk, bp_kept, addr, size};
    pop = (mq.size() != 0) && rdy;
    if (pop) begin
      void'(mq.pop_front());
      n_pops++;
    end
    if (m_phase == 0) begin
      if (ret) begin
        m_inst++;
        if (br) m_branch++;
        if (br && tk) m_taken++;
`ifdef RET_TRACE_BP_EN
        if (br && bp) m_bp++;
`endif
        if (size < 4) m_load++;
        else if (size < 8) m_store++;
        if (mq.size() < DEPTH) mq.push_back(rec);
        else begin
          m_drop++;
          m_ovf = 1'b1;
        end
      end
      if (tohost[0]) begin
        m_phase = 1;
        m_exit = tohost[31:1];
      end
    end else if (m_phase == 1) begin
      if (mq.size() == 0) m_phase = 2;
    end
  endtask

  task automatic rand_step(input logic ret, input logic rdy, input logic [31:0] tohost);
    int         k;
    logic [3:0] sz;
    logic [31:0] addr;
    k = $urandom_range(0, 6);
    sz = (k < 3) ? 4'(k) : ((k < 6) ? 4'(k + 1) : 4'd8);
    addr = (sz == 4'd8) ? 32'd0 : $urandom;
    step(ret, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), addr, sz,
         rdy, tohost);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd8, rdy, 32'd0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({out_valid, out_entry, done} !== 105'd0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%0b entry=%h done=%0b want all 0", out_valid, out_entry, done);
    end
    total++;
    if (dut_stats() !== 256'd0) begin
      bad++;
      $display("FAIL reset_stats got=%h want 0", dut_stats());
    end
  endtask

  task automatic test_basic();
    do_reset();
    n_pops = 0;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: step(1, 32'h0000_a283, 32'h8000_0000, 0, 0, 0, 32'h0000_1000, 4'd2, 1, 0);
        1: step(1, 32'h0062_8463, 32'h8000_0004, 1, 1, 1, 32'h0000_0000, 4'd8, 1, 0);
        2: step(1, 32'h0053_2023, 32'h8000_000c, 0, 0, 0, 32'h0000_2000, 4'd6, 1, 0);
        3: step(1, 32'h0013_0313, 32'h8000_0010, 0, 0, 0, 32'h0000_0000, 4'd8, 1, 0);
        4: step(1, 32'h0000_0013, 32'h8000_0014, 0, 0, 0, 32'h0000_0000, 4'd8, 1, 0);
        default: idle(1);
      endcase
      total++;
      if (o_out !== e_out) begin
        bad++;
        $display("FAIL basic_stream step=%0d got=%h want=%h", i, o_out, e_out);
      end
    end
    total++;
    if (n_pops != 5) begin
      bad++;
      $display("FAIL basic_pops got=%0d want=5", n_pops);
    end
    total++;
    if ({cnt_inst, cnt_branch, cnt_taken, cnt_load, cnt_store} !==
        {32'd5, 32'd1, 32'd1, 32'd1, 32'd1}) begin
      bad++;
      $display("FAIL basic_counts got inst=%0d br=%0d tk=%0d ld=%0d st=%0d want 5 1 1 1 1",
               cnt_inst, cnt_branch, cnt_taken, cnt_load, cnt_store);
    end
  endtask

  task automatic test_overflow();
    int seen;
    do_reset();
    for (int i = 0; i < 20; i++) rand_step(1, 0, 0);
    idle(0);
    total++;
    if ({cnt_drop, overflow, cnt_inst, out_valid} !== {32'd4, 1'b1, 32'd20, 1'b1}) begin
      bad++;
      $display("FAIL ovf_counts got drop=%0d ovf=%0b inst=%0d valid=%0b want 4 1 20 1",
               cnt_drop, overflow, cnt_inst, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (o_out[104]) seen++;
      total++;
      if (o_out !== e_out) begin
        bad++;
        $display("FAIL ovf_drain step=%0d got=%h want=%h", i, o_out, e_out);
      end
    end
    total++;
    if (seen != 16) begin
      bad++;
      $display("FAIL ovf_pop_count got=%0d want=16", seen);
    end
  endtask

  task automatic test_back_to_back();
    int seen;
    do_reset();
    for (int i = 0; i < 16; i++) rand_step(1, 0, 0);
    rand_step(1, 1, 0);
    idle(0);
    total++;
    if ({cnt_drop, overflow, cnt_inst} !== {32'd0, 1'b0, 32'd17}) begin
      bad++;
      $display("FAIL full_pushpop got drop=%0d ovf=%0b inst=%0d want 0 0 17", cnt_drop, overflow, cnt_inst);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (o_out[104]) seen++;
      total++;
      if (o_out !== e_out) begin
        bad++;
        $display("FAIL full_drain step=%0d got=%h want=%h", i, o_out, e_out);
      end
    end
    total++;
    if (seen != 16) begin
      bad++;
      $display("FAIL full_count got=%0d want=16", seen);
    end
  endtask

  task automatic test_drain(input logic [31:0] tohost, input logic ret_at_detect,
                            input logic [30:0] want_exit, input logic [31:0] want_inst);
    do_reset();
    for (int i = 0; i < 3; i++) rand_step(1, 0, 0);
    rand_step(ret_at_detect, 1, tohost);
    for (int i = 0; i < 8; i++) begin
      rand_step(1, 1, tohost);
      total++;
      if (o_out !== e_out) begin
        bad++;
        $display("FAIL drain_stream tohost=%h step=%0d got=%h want=%h", tohost, i, o_out, e_out);
      end
    end
    total++;
    if ({done, out_valid, exit_code, cnt_inst, cnt_drop} !==
        {1'b1, 1'b0, want_exit, want_inst, 32'd0}) begin
      bad++;
      $display("FAIL drain_end tohost=%h got done=%0b valid=%0b exit=%0d inst=%0d drop=%0d want 1 0 %0d %0d 0",
               tohost, done, out_valid, exit_code, cnt_inst, cnt_drop, want_exit, want_inst);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 8; i++) rand_step(1, 0, 0);
    do_reset();
    total++;
    if ({out_valid, done, dut_stats()} !== 258'd0) begin
      bad++;
      $display("FAIL midrst_clear got valid=%0b done=%0b stats=%h want 0", out_valid, done, dut_stats());
    end
    rand_step(1, 0, 0);
    idle(0);
    total++;
    if ({out_valid, cnt_inst, done} !== {1'b1, 32'd1, 1'b0}) begin
      bad++;
      $display("FAIL midrst_run got valid=%0b inst=%0d done=%0b want 1 1 0", out_valid, cnt_inst, done);
    end
  endtask

  task automatic test_bp_hit();
    logic [31:0] want;
`ifdef RET_TRACE_BP_EN
    want = 32'd4;
`else
    want = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, $urandom, $urandom, 1, 1'($urandom), 1, 32'd0, 4'd8, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      idle(1);
      total++;
      if (o_out !== e_out) begin
        bad++;
        $display("FAIL bp_entry step=%0d got=%h want=%h", i, o_out, e_out);
      end
    end
    total++;
    if ({cnt_bp_hit, cnt_branch} !== {want, 32'd4}) begin
      bad++;
      $display("FAIL bp_count got bp=%0d br=%0d want %0d 4", cnt_bp_hit, cnt_branch, want);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_step(($urandom_range(0, 9) < 7), 1'($urandom), 32'd0);
      total++;
      if (o_out !== e_out) begin
        bad++;
        $display("FAIL rand_stream step=%0d got=%h want=%h", i, o_out, e_out);
      end
    end
    rand_step(1'($urandom), 1'($urandom), 32'hABCD_0001);
    for (int i = 0; i < 60; i++) begin
      rand_step(1'($urandom), ($urandom_range(0, 3) != 0), 32'hABCD_0001);
      total++;
      if (o_out !== e_out) begin
        bad++;
        $display("FAIL rand_drain step=%0d got=%h want=%h", i, o_out, e_out);
      end
    end
    idle(0);
    total++;
    if (dut_stats() !== model_stats()) begin
      bad++;
      $display("FAIL rand_stats got=%h want=%h", dut_stats(), model_stats());
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_drain(32'h0000_0001, 1'b0, 31'd0, 32'd3);
    test_drain(32'h0000_0007, 1'b1, 31'd3, 32'd4);
    test_mid_reset();
    test_bp_hit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
